// File: rtl/snn_pkg.sv
// Shared spiking-network types and widths used by recurrent_layer and its readout stages.
package snn_pkg;
  localparam int N_NEURON = 4;
  localparam int V_W      = 8;
  localparam int W_W      = 8;
  localparam int CNT_W    = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } dec_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/spike_argmax.sv
// Combinational winner pick: highest count among active lanes, lowest index on ties.
module spike_argmax #(
  parameter int N     = 4,
  parameter int CNT_W = 5,
  parameter int ID_W  = 2
) (
  input  logic [N*CNT_W-1:0] i_counts,
  input  logic [N-1:0]       i_active,
  output logic [ID_W-1:0]    o_winner_id,
  output logic               o_winner_valid
);
  logic [CNT_W-1:0] w_best;
  logic             w_found;

  // Strict greater-than keeps the earliest lane on equal counts.
  always_comb begin
    w_best  = '0;
    w_found = 1'b0;
    o_winner_id = '0;
    for (int i = 0; i < N; i++) begin
      if (i_active[i] && (!w_found || i_counts[i*CNT_W +: CNT_W] > w_best)) begin
        w_best      = i_counts[i*CNT_W +: CNT_W];
        w_found     = 1'b1;
        o_winner_id = ID_W'(i);
      end
    end
    o_winner_valid = w_found;
  end
endmodule

// File: rtl/spike_window_decoder.sv
// Windowed spike counter for recurrent_layer output: per-lane saturating counts,
// threshold mask and winner presented on valid/ready, with sticky overrun on dropped results.
module spike_window_decoder
  import snn_pkg::*;
#(
  parameter int N_NEURON = snn_pkg::N_NEURON,
  parameter int WIN_LEN  = 16,
  parameter int CNT_W    = snn_pkg::CNT_W,
  parameter int FIRE_TH  = 4,
  parameter int ID_W     = snn_pkg::idx_width(N_NEURON),
  parameter int PW       = $clog2(WIN_LEN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_NEURON-1:0]       spike_in,
  input  logic                      enable,
  input  logic                      clear,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [N_NEURON*CNT_W-1:0] spike_count,
  output logic [N_NEURON-1:0]       active_mask,
  output logic [ID_W-1:0]           winner_id,
  output logic                      winner_valid,
  output logic [PW-1:0]             win_pos,
  output logic                      overrun
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  dec_state_t                r_state, w_state_nxt;
  logic                      w_sample, w_close;
  logic [CNT_W-1:0]          r_cnt     [N_NEURON];
  logic [CNT_W-1:0]          w_cnt_inc [N_NEURON];
  logic [N_NEURON*CNT_W-1:0] w_cnt_flat;
  logic [N_NEURON-1:0]       w_active;
  logic [PW-1:0]             r_win_pos;
  logic [ID_W-1:0]           w_win_id;
  logic                      w_win_vld;
  logic                      r_out_valid, r_overrun, r_winner_valid;
  logic [N_NEURON*CNT_W-1:0] r_spike_count;
  logic [N_NEURON-1:0]       r_active_mask;
  logic [ID_W-1:0]           r_winner_id;

  always_comb begin
    w_state_nxt = r_state;
    w_sample    = 1'b0;
    case (r_state)
      IDLE: if (enable) begin
        w_state_nxt = ACCUM;
        w_sample    = 1'b1;
      end
      ACCUM: if (enable) w_sample = 1'b1;
             else        w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Incremented view includes this cycle's sample so a closing window counts it.
  always_comb begin
    w_cnt_flat = '0;
    w_active   = '0;
    for (int i = 0; i < N_NEURON; i++) begin
      w_cnt_inc[i] = (spike_in[i] && r_cnt[i] != CNT_MAX) ? r_cnt[i] + CNT_W'(1) : r_cnt[i];
      w_cnt_flat[i*CNT_W +: CNT_W] = w_cnt_inc[i];
      w_active[i] = (w_cnt_inc[i] >= CNT_W'(FIRE_TH));
    end
  end

  assign w_close = w_sample && !clear && (r_win_pos == PW'(WIN_LEN - 1));

  spike_argmax #(.N(N_NEURON), .CNT_W(CNT_W), .ID_W(ID_W)) u_argmax (
    .i_counts       (w_cnt_flat),
    .i_active       (w_active),
    .o_winner_id    (w_win_id),
    .o_winner_valid (w_win_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_pos <= '0;
      for (int i = 0; i < N_NEURON; i++) r_cnt[i] <= '0;
    end else if (clear || w_close) begin
      r_win_pos <= '0;
      for (int i = 0; i < N_NEURON; i++) r_cnt[i] <= '0;
    end else if (w_sample) begin
      r_win_pos <= r_win_pos + PW'(1);
      for (int i = 0; i < N_NEURON; i++) r_cnt[i] <= w_cnt_inc[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid    <= 1'b0;
      r_overrun      <= 1'b0;
      r_spike_count  <= '0;
      r_active_mask  <= '0;
      r_winner_id    <= '0;
      r_winner_valid <= 1'b0;
    end else begin
      if (w_close) begin
        r_out_valid    <= 1'b1;
        r_spike_count  <= w_cnt_flat;
        r_active_mask  <= w_active;
        r_winner_id    <= w_win_id;
        r_winner_valid <= w_win_vld;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (clear)                                       r_overrun <= 1'b0;
      else if (w_close && r_out_valid && !out_ready)   r_overrun <= 1'b1;
    end
  end

  assign out_valid    = r_out_valid;
  assign spike_count  = r_spike_count;
  assign active_mask  = r_active_mask;
  assign winner_id    = r_winner_id;
  assign winner_valid = r_winner_valid;
  assign win_pos      = r_win_pos;
  assign overrun      = r_overrun;
endmodule

// File: tb/tb_spike_window_decoder.sv
// Directed bench for spike_window_decoder: default instance plus a WIN_LEN=40 instance for saturation.
module tb_spike_window_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  spike_in = '0;
  logic        enable = 1'b0, clear = 1'b0, out_ready = 1'b0;
  logic        out_valid, winner_valid, overrun;
  logic [19:0] spike_count;
  logic [3:0]  active_mask, win_pos;
  logic [1:0]  winner_id;

  logic [3:0]  spike2 = '0;
  logic        en2 = 1'b0, clr2 = 1'b0, rdy2 = 1'b1;
  logic        valid2, wvalid2, overrun2;
  logic [19:0] count2;
  logic [3:0]  mask2;
  logic [1:0]  wid2;
  logic [5:0]  pos2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spike_window_decoder dut (
    .clk(clk), .rst(rst), .spike_in(spike_in), .enable(enable), .clear(clear),
    .out_ready(out_ready), .out_valid(out_valid), .spike_count(spike_count),
    .active_mask(active_mask), .winner_id(winner_id), .winner_valid(winner_valid),
    .win_pos(win_pos), .overrun(overrun)
  );

  spike_window_decoder #(.WIN_LEN(40), .CNT_W(5)) dut_sat (
    .clk(clk), .rst(rst), .spike_in(spike2), .enable(en2), .clear(clr2),
    .out_ready(rdy2), .out_valid(valid2), .spike_count(count2),
    .active_mask(mask2), .winner_id(wid2), .winner_valid(wvalid2),
    .win_pos(pos2), .overrun(overrun2)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [3:0] s, input int n);
    enable = 1'b1; spike_in = s;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; #12;
    n_checks++;
    if ({out_valid, spike_count, active_mask, winner_id, winner_valid, win_pos, overrun} !== '0) begin
      n_fail++; $display("FAIL reset_state: got valid=%b cnt=%h mask=%b id=%0d wv=%b pos=%0d ovr=%b, want all 0",
        out_valid, spike_count, active_mask, winner_id, winner_valid, win_pos, overrun);
    end
    rst = 1'b0; tick();
  endtask

  task automatic test_pattern_a();
    out_ready = 1'b1;
    run(4'b0011, 15);
    n_checks++;
    if (out_valid !== 1'b0 || win_pos !== 4'd15) begin
      n_fail++; $display("FAIL patA_latency: valid=%b pos=%0d, want 0/15", out_valid, win_pos);
    end
    run(4'b0011, 1);
    n_checks++;
    if (out_valid !== 1'b1 || spike_count !== {5'd0, 5'd0, 5'd16, 5'd16} || active_mask !== 4'b0011 ||
        winner_id !== 2'd0 || winner_valid !== 1'b1 || win_pos !== 4'd0) begin
      n_fail++; $display("FAIL patA_result: valid=%b cnt=%h mask=%b id=%0d wv=%b pos=%0d, want 1/%h/0011/0/1/0",
        out_valid, spike_count, active_mask, winner_id, winner_valid, win_pos, {5'd0, 5'd0, 5'd16, 5'd16});
    end
    enable = 1'b0; tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL patA_drop: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_threshold_tie();
    out_ready = 1'b1;
    run(4'b0100, 3); run(4'b1000, 5); run(4'b0000, 8);
    n_checks++;
    if (out_valid !== 1'b1 || spike_count !== {5'd5, 5'd3, 5'd0, 5'd0} || active_mask !== 4'b1000 ||
        winner_id !== 2'd3 || winner_valid !== 1'b1) begin
      n_fail++; $display("FAIL threshold: valid=%b cnt=%h mask=%b id=%0d wv=%b, want 1/%h/1000/3/1",
        out_valid, spike_count, active_mask, winner_id, winner_valid, {5'd5, 5'd3, 5'd0, 5'd0});
    end
    run(4'b0100, 6); run(4'b1000, 6); run(4'b0000, 4);
    n_checks++;
    if (spike_count !== {5'd6, 5'd6, 5'd0, 5'd0} || active_mask !== 4'b1100 || winner_id !== 2'd2) begin
      n_fail++; $display("FAIL tie: cnt=%h mask=%b id=%0d, want %h/1100/2",
        spike_count, active_mask, winner_id, {5'd6, 5'd6, 5'd0, 5'd0});
    end
    run(4'b0001, 4); run(4'b0000, 12);
    n_checks++;
    if (spike_count !== {5'd0, 5'd0, 5'd0, 5'd4} || active_mask !== 4'b0001 || winner_id !== 2'd0 ||
        winner_valid !== 1'b1) begin
      n_fail++; $display("FAIL th_edge: cnt=%h mask=%b id=%0d wv=%b, want %h/0001/0/1",
        spike_count, active_mask, winner_id, winner_valid, {5'd0, 5'd0, 5'd0, 5'd4});
    end
    enable = 1'b0; tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    run(4'b0001, 16);
    n_checks++;
    if (out_valid !== 1'b1 || overrun !== 1'b0 || spike_count !== {5'd0, 5'd0, 5'd0, 5'd16}) begin
      n_fail++; $display("FAIL bp_first: valid=%b ovr=%b cnt=%h, want 1/0/%h", out_valid, overrun,
        spike_count, {5'd0, 5'd0, 5'd0, 5'd16});
    end
    run(4'b0010, 8);
    n_checks++;
    if (out_valid !== 1'b1 || spike_count !== {5'd0, 5'd0, 5'd0, 5'd16} || overrun !== 1'b0) begin
      n_fail++; $display("FAIL bp_hold: valid=%b cnt=%h ovr=%b, want stable first result", out_valid, spike_count, overrun);
    end
    run(4'b0010, 8);
    n_checks++;
    if (out_valid !== 1'b1 || overrun !== 1'b1 || spike_count !== {5'd0, 5'd0, 5'd16, 5'd0} || winner_id !== 2'd1) begin
      n_fail++; $display("FAIL bp_overrun: valid=%b ovr=%b cnt=%h id=%0d, want 1/1/%h/1",
        out_valid, overrun, spike_count, winner_id, {5'd0, 5'd0, 5'd16, 5'd0});
    end
    enable = 1'b0; clear = 1'b1; tick();
    clear = 1'b0;
    n_checks++;
    if (overrun !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_clear: ovr=%b valid=%b, want 0/1", overrun, out_valid);
    end
    out_ready = 1'b1; tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_accept: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_abort_reset();
    out_ready = 1'b0;
    run(4'b1111, 9);
    clear = 1'b1; tick(); clear = 1'b0;
    n_checks++;
    if (win_pos !== 4'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort: pos=%0d valid=%b, want 0/0", win_pos, out_valid);
    end
    run(4'b0001, 15);
    n_checks++;
    if (out_valid !== 1'b0 || win_pos !== 4'd15) begin
      n_fail++; $display("FAIL abort_restart: valid=%b pos=%0d, want 0/15", out_valid, win_pos);
    end
    run(4'b0001, 1);
    n_checks++;
    if (out_valid !== 1'b1 || spike_count !== {5'd0, 5'd0, 5'd0, 5'd16}) begin
      n_fail++; $display("FAIL abort_counts: valid=%b cnt=%h, want 1/%h", out_valid, spike_count, {5'd0, 5'd0, 5'd0, 5'd16});
    end
    run(4'b1111, 5);
    rst = 1'b1; #2;
    n_checks++;
    if ({out_valid, spike_count, active_mask, winner_id, winner_valid, win_pos, overrun} !== '0) begin
      n_fail++; $display("FAIL async_reset: valid=%b cnt=%h mask=%b pos=%0d, want all 0",
        out_valid, spike_count, active_mask, win_pos);
    end
    rst = 1'b0; out_ready = 1'b1;
    run(4'b0101, 16);
    n_checks++;
    if (out_valid !== 1'b1 || spike_count !== {5'd0, 5'd16, 5'd0, 5'd16} || active_mask !== 4'b0101 ||
        winner_id !== 2'd0) begin
      n_fail++; $display("FAIL post_reset: valid=%b cnt=%h mask=%b id=%0d, want 1/%h/0101/0",
        out_valid, spike_count, active_mask, winner_id, {5'd0, 5'd16, 5'd0, 5'd16});
    end
    enable = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; enable = 1'b1; spike_in = 4'b1111;
    for (int c = 1; c <= 48; c++) begin
      tick();
      n_checks++;
      if (out_valid !== (c % 16 == 0)) begin
        n_fail++; $display("FAIL b2b_valid cycle %0d: valid=%b, want %b", c, out_valid, (c % 16 == 0));
      end
      if (c % 16 == 0) begin
        n_checks++;
        if (spike_count !== {4{5'd16}} || winner_id !== 2'd0 || overrun !== 1'b0) begin
          n_fail++; $display("FAIL b2b_result cycle %0d: cnt=%h id=%0d ovr=%b, want %h/0/0",
            c, spike_count, winner_id, overrun, {4{5'd16}});
        end
      end
    end
    enable = 1'b0; tick();
  endtask

  task automatic test_pause_saturation();
    en2 = 1'b1; spike2 = 4'b0001;
    repeat (20) tick();
    en2 = 1'b0;
    repeat (7) tick();
    n_checks++;
    if (pos2 !== 6'd20 || valid2 !== 1'b0) begin
      n_fail++; $display("FAIL pause_hold: pos=%0d valid=%b, want 20/0", pos2, valid2);
    end
    en2 = 1'b1;
    repeat (19) tick();
    n_checks++;
    if (valid2 !== 1'b0 || pos2 !== 6'd39) begin
      n_fail++; $display("FAIL pause_early: valid=%b pos=%0d, want 0/39", valid2, pos2);
    end
    tick();
    n_checks++;
    if (valid2 !== 1'b1 || count2 !== {15'd0, 5'd31} || mask2 !== 4'b0001 || wid2 !== 2'd0 || wvalid2 !== 1'b1) begin
      n_fail++; $display("FAIL saturate: valid=%b cnt=%h mask=%b id=%0d wv=%b, want 1/%h/0001/0/1",
        valid2, count2, mask2, wid2, wvalid2, {15'd0, 5'd31});
    end
    en2 = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_pattern_a();
    test_threshold_tie();
    test_backpressure();
    test_abort_reset();
    test_back_to_back();
    test_pause_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spike_window_decoder.md
Name: spike_window_decoder

Overview:
- Downstream readout stage for recurrent_layer. Consumes its spike_out bus.
- Counts spikes per neuron over fixed-length windows and classifies each neuron as active or inactive against a threshold.
- Picks the winning neuron and presents each window result on a valid/ready interface.
- This is how the pattern-completion result (e.g. N0 stimulus yielding N0+N1 firing) becomes a discrete pattern code for downstream logic or host capture.

Parameters:
- N_NEURON, 4, number of spike lanes; must match recurrent_layer.
- WIN_LEN, 16, enabled sample cycles per window (≥2).
- CNT_W, 5, per-neuron counter width; counters saturate at 2^CNT_W-1.
- FIRE_TH, 4, minimum window count for a neuron to be marked active (1..2^CNT_W-1).
- ID_W, 2, winner index width, equal to clog2(N_NEURON).

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- spike_in, input, N_NEURON, spike vector from recurrent_layer spike_out; sampled every enabled cycle.
- enable, input, 1, sample qualifier; when low, window progress and counts freeze.
- clear, input, 1, synchronous abort; zeroes counts, window position and the overrun flag. Output registers are untouched.
- out_ready, input, 1, consumer accepts the result.
- out_valid, output, 1, window result available.
- spike_count, output, N_NEURON*CNT_W, latched per-neuron counts; lane i occupies bits [i*CNT_W +: CNT_W].
- active_mask, output, N_NEURON, bit i = latched count_i ≥ FIRE_TH.
- winner_id, output, ID_W, index of the highest-count active neuron.
- winner_valid, output, 1, active_mask is nonzero.
- win_pos, output, clog2(WIN_LEN), current position inside the window being accumulated.
- overrun, output, 1, sticky flag: a result was overwritten before it was accepted.

Behaviour:
- Reset (async, rst=1): all counters, win_pos, out_valid, spike_count, active_mask, winner_id, winner_valid and overrun go to 0.
- FSM states:
  - IDLE: after reset, or when enable=0. Counts and win_pos are held.
  - ACCUM: enable=1.
  - Transitions: IDLE→ACCUM when enable=1; ACCUM→IDLE when enable=0.
  - Pausing never discards partial window data.
- In ACCUM, each edge:
  - count_i += spike_in[i], saturating at 2^CNT_W-1 with no wrap.
  - win_pos increments.
- Window close: on the edge where enable=1 and win_pos==WIN_LEN-1:
  - Output registers load count_i + spike_in[i] (saturated), so the final sample is included.
  - active_mask, winner_id and winner_valid are computed from those same values.
  - Working counts and win_pos reset to 0 on the same edge; the next window starts with no gap.
- Latency: out_valid rises directly after the WIN_LEN-th enabled sampling edge.
- Winner selection:
  - Among active neurons only, pick the maximum count; ties go to the lowest index.
  - If no neuron is active: winner_id=0 and winner_valid=0.
- Handshake:
  - A transfer happens on an edge where out_valid=1 and out_ready=1.
  - Output data is stable while out_valid=1 and out_ready=0, unless it is overrun.
  - After a transfer with no coincident close, out_valid drops to 0.
  - Transfer and close on the same edge: new data loads, out_valid stays 1, no overrun.
  - Close while out_valid=1 and out_ready=0: new data overwrites the old, out_valid stays 1, overrun is set.
- overrun stays set until rst or clear.
- clear:
  - Has priority over sampling on the same edge; that cycle's spikes are dropped and no window close occurs.
  - Does not drop out_valid.
- Reset mid-window: all state is lost immediately; the window restarts from 0 after reset deasserts.
- spike_in is treated as synchronous (it is a registered recurrent_layer output); no synchroniser is needed.

Decomposition:
- Package snn_pkg holds:
  - N_NEURON default;
  - V_W=8 and W_W=8 (shared with recurrent_layer);
  - CNT_W default;
  - a function for the winner-index width.
- Sub-module spike_argmax: combinational max/index tree over N_NEURON counts plus the active mask, with lowest-index tie-break. The decoder instantiates it once, on the close path, feeding the output registers.
- The top level holds the FSM, window counter, saturating counters and handshake registers.

Test Plan:
- Pattern A readout: enable=1, spike_in=0011 for 16 cycles, out_ready=1 → out_valid for 1 cycle; counts {16,16,0,0}; active_mask=0011; winner_id=0; winner_valid=1.
- Threshold and tie:
  - spike_in=0100 on 3 cycles and 1000 on 5 cycles → mask=1000, winner_id=3, counts {0,0,3,5}.
  - Next window: 0100 and 1000 each 6 times → mask=1100, winner_id=2.
- Backpressure and overrun: out_ready=0 over two complete windows → out_valid stays 1; second result replaces the first; overrun=1. Then clear=1 → overrun=0 with out_valid still 1. Then out_ready=1 → out_valid=0 next cycle.
- Pause and saturation: WIN_LEN=40, CNT_W=5, spike_in=0001 throughout, enable low for 7 cycles mid-window → close occurs only after 40 enabled cycles; count_0=31 (saturated).
- Abort and reset: clear at win_pos=9 → win_pos=0, counts 0, no result. Assert rst at win_pos=5 → all outputs 0 immediately, asynchronously. After release, a full window produces the correct counts.
- Back-to-back: continuous spike_in=1111 with out_ready=1 → out_valid pulses every 16 cycles; counts {16,16,16,16}; winner_id=0; overrun stays 0.
